// File: rtl/xor_fenwick_bank_pkg.sv
// Shared constants and types for the XOR Fenwick storage bank.
//   DEPTH  : entry count, tied to the 8-bit decoder masks
//   MASK_W : width of the upstream index-decoder masks
//   CNT_W  : clear-sweep counter width
//   state_t: bank control state
package xor_fenwick_bank_pkg;

    localparam int DEPTH  = 8;
    localparam int MASK_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/xor_fenwick_bank_reduce.sv
// xor_reduce8: combinational masked XOR-reduction of eight WIDTH-bit words.
//   words  : eight candidate words, words[i] is entry i
//   mask   : bit i selects words[i] into the reduction
//   result : XOR of all selected words (0 when mask is 0)
module xor_reduce8
    import xor_fenwick_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [DEPTH-1:0][WIDTH-1:0] words,
    input  logic [MASK_W-1:0]           mask,
    output logic [WIDTH-1:0]            result
);

    always_comb begin
        result = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mask[i]) result = result ^ words[i];
        end
    end

endmodule

// File: rtl/xor_fenwick_bank.sv
// xor_fenwick_bank: eight-entry XOR storage bank driven by decoder masks.
//   clk, rst           : clock and synchronous active-high reset
//   upd_valid/ready    : update handshake; upd_mask selects entries, upd_data is the XOR delta
//   qry_valid/ready    : query handshake; qry_mask selects entries to XOR-reduce
//   res_valid/ready    : result handshake; res_data holds the reduced value
//   clr_req            : single-cycle request to zero the bank (8-cycle sweep)
//   busy               : high while the clear sweep runs
module xor_fenwick_bank
    import xor_fenwick_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [MASK_W-1:0] upd_mask,
    input  logic [WIDTH-1:0]  upd_data,
    input  logic              qry_valid,
    output logic              qry_ready,
    input  logic [MASK_W-1:0] qry_mask,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    input  logic              clr_req,
    output logic              busy
);

    state_t                      state, state_nx;
    logic [CNT_W-1:0]            cnt;
    logic [DEPTH-1:0][WIDTH-1:0] entry, entry_next;
    logic [WIDTH-1:0]            qry_result;
    logic                        upd_fire, qry_fire;

    assign upd_ready = (state == IDLE);
    assign qry_ready = (state == IDLE) & (~res_valid | res_ready);
    assign busy      = (state == CLEAR);
    assign upd_fire  = upd_valid & upd_ready;
    assign qry_fire  = qry_valid & qry_ready;

    // Post-update entry values; the query reduces these so an update and a
    // query accepted on the same edge see each other (write-before-read).
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign entry_next[i] = (upd_fire && upd_mask[i]) ? (entry[i] ^ upd_data) : entry[i];
    end

    xor_reduce8 #(.WIDTH(WIDTH)) u_reduce (
        .words  (entry_next),
        .mask   (qry_mask),
        .result (qry_result)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (clr_req) state_nx = CLEAR;
            CLEAR:   if (cnt == CNT_W'(DEPTH - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            entry <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                entry <= entry_next;
                if (clr_req) cnt <= '0;
            end else begin
                // One entry per cycle; counter wraps back to 0 after entry 7.
                entry[cnt] <= '0;
                cnt        <= cnt + CNT_W'(1);
            end
        end
    end

    // Result register: reload on accepted query, otherwise drop valid on
    // consumption. Untouched by the clear sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (qry_fire) begin
            res_valid <= 1'b1;
            res_data  <= qry_result;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
